// File: rtl/prog_ctr_pkg.sv
// Shared types and defaults for the program-counter fetch stage.
// Holds the run-state enum and the next-PC source enum.
package prog_ctr_pkg;

  localparam int DEFAULT_D = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_e;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    ABS,
    REL,
    CALL,
    RET
  } pc_sel_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack used by call/return; synchronous clear empties it
// when a program (re)starts.
module ret_addr_stack #(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(STACK_DEPTH);

  logic [PW:0]   sp_q, sp_d;
  logic [D-1:0]  mem_q [STACK_DEPTH];
  logic [D-1:0]  mem_d [STACK_DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;

  // The pointer carries one extra bit so full and empty stay distinguishable.
  assign wr_idx = sp_q[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);
  assign top    = mem_q[rd_idx];
  assign full   = (sp_q == (PW+1)'(STACK_DEPTH));
  assign empty  = (sp_q == '0);

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_d[i] = '0;
    end else if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencing: picks the next instruction address
// from hold/increment/jump/branch/call/return and tracks run/halt status.
module prog_ctr_fetch
  import prog_ctr_pkg::*;
#(
  parameter int D           = DEFAULT_D,
  parameter int STACK_DEPTH = 4,
  parameter int OFS_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             AbsJump,
  input  logic             RelJump,
  input  logic             Taken,
  input  logic             Call,
  input  logic             Ret,
  input  logic [D-1:0]     Target,
  input  logic [OFS_W-1:0] Offset,
  output logic [D-1:0]     ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             StackErr
);

  state_e       state_q, state_d;
  pc_sel_e      pc_sel;
  logic [D-1:0] pc_q, pc_d;
  logic         stack_err_q, stack_err_d;
  logic         stk_push, stk_pop, stk_clear;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_top;
  logic [D-1:0] pc_inc;
  logic [D-1:0] offset_ext;

  assign pc_inc     = pc_q + D'(1);
  assign offset_ext = {{(D-OFS_W){Offset[OFS_W-1]}}, Offset};

  ret_addr_stack #(
    .D          (D),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clear    (stk_clear),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(pc_inc),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  // Fixed-priority request decode; stack faults halt with the PC held.
  always_comb begin
    state_d     = state_q;
    stack_err_d = stack_err_q;
    pc_sel      = HOLD;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_clear   = 1'b0;
    case (state_q)
      RUN: begin
        if (Halt) begin
          state_d = HALTED;
        end else if (Stall) begin
          pc_sel = HOLD;
        end else if (Ret) begin
          if (stk_empty) begin
            stack_err_d = 1'b1;
            state_d     = HALTED;
          end else begin
            stk_pop = 1'b1;
            pc_sel  = RET;
          end
        end else if (Call) begin
          if (stk_full) begin
            stack_err_d = 1'b1;
            state_d     = HALTED;
          end else begin
            stk_push = 1'b1;
            pc_sel   = CALL;
          end
        end else if (AbsJump) begin
          pc_sel = ABS;
        end else if (RelJump && Taken) begin
          pc_sel = REL;
        end else begin
          pc_sel = INC;
        end
      end
      default: begin
        if (Start) begin
          state_d     = RUN;
          stack_err_d = 1'b0;
          stk_clear   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (stk_clear) begin
      pc_d = '0;
    end else begin
      case (pc_sel)
        INC:       pc_d = pc_inc;
        ABS, CALL: pc_d = Target;
        REL:       pc_d = pc_q + offset_ext;
        RET:       pc_d = stk_top;
        default:   pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign ProgCtr  = pc_q;
  assign Running  = (state_q == RUN);
  assign Done     = (state_q == HALTED);
  assign StackErr = stack_err_q;

endmodule
